step_motor_ctrl: RTL

Parametrised stepper controller, the successor to the single-pulse unipolar driver. It accepts move commands (step count, direction, step period) through a valid/ready handshake and generates the step timing internally. It supports wave, full and half-step excitation and tracks absolute position. It powers down the coils after a programmable idle time, and sits between the game/phase control logic and the 4-wire unipolar motor outputs.

---
 rtl/step_motor_ctrl_if.sv | 15 +
 rtl/step_motor_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/step_motor_ctrl_if.sv
// Move-command handshake bundle for step_motor_ctrl.
// Master drives the command; slave returns cmd_ready.
interface step_motor_ctrl_if #(
   parameter int unsigned PER_W = 20,
   parameter int unsigned CNT_W = 16
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_steps;
   logic             cmd_dir;
   logic [PER_W-1:0] cmd_period;

   modport master (output cmd_valid, cmd_steps, cmd_dir, cmd_period, input cmd_ready);
   modport slave  (input cmd_valid, cmd_steps, cmd_dir, cmd_period, output cmd_ready);
endinterface

// File: rtl/step_motor_ctrl.sv
// Unipolar stepper controller: queued-free move commands, wave/full/half excitation,
// absolute position tracking and idle coil power-down. Optional soft start: STEP_RAMP_EN.
module step_motor_ctrl #(
   parameter int unsigned PER_W    = 20,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned POS_W    = 24,
   parameter int unsigned IDLE_CYC = 1000000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   step_motor_ctrl_if.slave        i_cmd,
   input  logic [1:0]              i_mode,
   input  logic                    i_step_pulse,
   input  logic                    i_dir,
   input  logic                    i_abort,
   output logic                    o_busy,
   output logic                    o_done,
   output logic signed [POS_W-1:0] o_position,
   output logic [3:0]              o_motor_phase
);

`ifdef STEP_RAMP_EN
   localparam int unsigned TW = PER_W + 2;
`else
   localparam int unsigned TW = PER_W;
`endif
   localparam int unsigned IDLE_W = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           r_state;
   logic [2:0]       r_idx;
   logic [POS_W-1:0] r_pos;
   logic [CNT_W-1:0] r_remain;
   logic             r_dir;
   logic [PER_W-1:0] r_period;
   logic [TW-1:0]    r_per_cnt;
   logic             r_energ;
   logic [IDLE_W-1:0] r_idle;
   logic [3:0]       r_phase;
   logic             r_done;
`ifdef STEP_RAMP_EN
   logic [1:0]       r_step_no;
`endif

   logic             w_idle;
   logic             w_accept;
   logic [TW-1:0]    w_interval;
   logic             w_run_step;
   logic             w_manual;
   logic             w_step;
   logic             w_step_dir;
   logic [2:0]       w_dl;
   logic [2:0]       w_idx_next;
   logic [POS_W-1:0] w_pos_next;
   logic             w_timeout;
   logic             w_energ_next;
   logic [2:0]       w_eff;

   function automatic logic [3:0] phase_of(input logic [2:0] e);
      case (e)
         3'd0: phase_of = 4'b1000;
         3'd1: phase_of = 4'b1100;
         3'd2: phase_of = 4'b0100;
         3'd3: phase_of = 4'b0110;
         3'd4: phase_of = 4'b0010;
         3'd5: phase_of = 4'b0011;
         3'd6: phase_of = 4'b0001;
         default: phase_of = 4'b1001;
      endcase
   endfunction

   assign w_idle          = (r_state == S_IDLE);
   assign i_cmd.cmd_ready = w_idle && !i_abort;
   assign w_accept        = i_cmd.cmd_valid && i_cmd.cmd_ready;

   // Step interval for the current step; soft start stretches the first two.
   always_comb begin
      w_interval = TW'(r_period);
`ifdef STEP_RAMP_EN
      if (r_step_no == 2'd0)      w_interval = {r_period, 2'b00};
      else if (r_step_no == 2'd1) w_interval = {1'b0, r_period, 1'b0};
`endif
   end

   always_comb begin
      w_run_step   = (r_state == S_RUN) && !i_abort && (r_per_cnt == w_interval - TW'(1));
      w_manual     = w_idle && i_step_pulse;
      w_step       = w_run_step || w_manual;
      w_step_dir   = w_manual ? i_dir : r_dir;
      w_dl         = i_mode[1] ? 3'd1 : 3'd2;
      w_idx_next   = r_idx;
      w_pos_next   = r_pos;
      if (w_step) begin
         w_idx_next = w_step_dir ? (r_idx - w_dl) : (r_idx + w_dl);
         w_pos_next = w_step_dir ? (r_pos - POS_W'(w_dl)) : (r_pos + POS_W'(w_dl));
      end
      w_timeout    = (IDLE_CYC != 0) && w_idle && r_energ &&
                     (r_idle == IDLE_W'(IDLE_CYC - 1));
      w_energ_next = w_step ? 1'b1 : (w_timeout ? 1'b0 : r_energ);
      // Full mode drives the two-coil odd entries, wave mode the single-coil even ones.
      w_eff        = i_mode[1] ? w_idx_next : {w_idx_next[2:1], i_mode[0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_pos     <= '0;
         r_remain  <= '0;
         r_dir     <= 1'b0;
         r_period  <= PER_W'(1);
         r_per_cnt <= '0;
         r_energ   <= 1'b0;
         r_idle    <= '0;
         r_phase   <= 4'b0000;
         r_done    <= 1'b0;
`ifdef STEP_RAMP_EN
         r_step_no <= 2'd0;
`endif
      end else begin
         r_done  <= 1'b0;
         r_idx   <= w_idx_next;
         r_pos   <= w_pos_next;
         r_energ <= w_energ_next;
         r_phase <= w_energ_next ? phase_of(w_eff) : 4'b0000;

         if (w_step || !w_idle)
            r_idle <= '0;
         else if (r_energ && !w_timeout)
            r_idle <= r_idle + IDLE_W'(1);

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_dir     <= i_cmd.cmd_dir;
                  r_period  <= (i_cmd.cmd_period == '0) ? PER_W'(1) : i_cmd.cmd_period;
                  r_remain  <= i_cmd.cmd_steps;
                  r_per_cnt <= '0;
`ifdef STEP_RAMP_EN
                  r_step_no <= 2'd0;
`endif
                  if (i_cmd.cmd_steps == '0) r_done  <= 1'b1;
                  else                       r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (i_abort) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end else if (w_run_step) begin
                  r_per_cnt <= '0;
                  r_remain  <= r_remain - CNT_W'(1);
`ifdef STEP_RAMP_EN
                  if (r_step_no != 2'd2) r_step_no <= r_step_no + 2'd1;
`endif
                  if (r_remain == CNT_W'(1)) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_per_cnt <= r_per_cnt + TW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy        = (r_state == S_RUN);
   assign o_done        = r_done;
   assign o_position    = $signed(r_pos);
   assign o_motor_phase = r_phase;

endmodule
